// File: rtl/fifo_stream_adapter_if.sv
// rtl/fifo_stream_adapter_if.sv - FIFO read side and output stream signals of fifo_stream_adapter
// master: the adapter; slave: the FIFO plus downstream consumer.
interface fifo_stream_adapter_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  fifo_empty_i;
  logic                  fifo_rd_en_o;
  logic                  fifo_rd_data_vaild_i;
  logic [DATA_WIDTH-1:0] fifo_rd_data_i;
  logic                  m_valid_o;
  logic [DATA_WIDTH-1:0] m_data_o;
  logic                  m_ready_i;
  logic                  m_last_o;
  logic                  ovf_err_o;

  modport master (
    input  fifo_empty_i, fifo_rd_data_vaild_i, fifo_rd_data_i, m_ready_i,
    output fifo_rd_en_o, m_valid_o, m_data_o, m_last_o, ovf_err_o
  );

  modport slave (
    output fifo_empty_i, fifo_rd_data_vaild_i, fifo_rd_data_i, m_ready_i,
    input  fifo_rd_en_o, m_valid_o, m_data_o, m_last_o, ovf_err_o
  );
endinterface

// File: rtl/fifo_stream_adapter.sv
// rtl/fifo_stream_adapter.sv - drains a 1-cycle-latency FIFO into a valid/ready stream via a 2-entry buffer
// Optional burst last-beat marking is built when FIFO_STREAM_LAST_EN is defined.
module fifo_stream_adapter #(
  parameter int DATA_WIDTH = 32,
  parameter int BURST_LEN  = 4,
  parameter int CNT_WIDTH  = $clog2(BURST_LEN)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fifo_stream_adapter_if.master bus
);

  logic [1:0]            occ;
  logic                  inflight;
  logic [DATA_WIDTH-1:0] head;
  logic [DATA_WIDTH-1:0] skid;
  logic                  ovf;
  logic                  pop;
  logic                  push;
  logic [2:0]            demand;
  logic                  rd_en;

  // Words already buffered plus the one in flight must leave room for the next read.
  assign pop    = (occ != 2'd0) && bus.m_ready_i;
  assign push   = bus.fifo_rd_data_vaild_i;
  assign demand = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
  assign rd_en  = rst_n && !bus.fifo_empty_i && (demand < 3'd2);

  assign bus.fifo_rd_en_o = rd_en;
  assign bus.m_valid_o    = (occ != 2'd0);
  assign bus.m_data_o     = head;
  assign bus.ovf_err_o    = ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ      <= 2'd0;
      inflight <= 1'b0;
      head     <= '0;
      skid     <= '0;
      ovf      <= 1'b0;
    end else begin
      inflight <= rd_en;
      case ({push, pop})
        2'b10: begin
          case (occ)
            2'd0: begin
              head <= bus.fifo_rd_data_i;
              occ  <= 2'd1;
            end
            2'd1: begin
              skid <= bus.fifo_rd_data_i;
              occ  <= 2'd2;
            end
            default: ovf <= 1'b1;
          endcase
        end
        2'b01: begin
          if (occ == 2'd2) head <= skid;
          occ <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd2) begin
            head <= skid;
            skid <= bus.fifo_rd_data_i;
          end else begin
            head <= bus.fifo_rd_data_i;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef FIFO_STREAM_LAST_EN
  localparam logic [CNT_WIDTH-1:0] LAST_BEAT = CNT_WIDTH'(BURST_LEN - 1);

  logic [CNT_WIDTH-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (pop) begin
      cnt <= (cnt == LAST_BEAT) ? '0 : cnt + CNT_WIDTH'(1);
    end
  end

  assign bus.m_last_o = (occ != 2'd0) && (cnt == LAST_BEAT);
`else
  assign bus.m_last_o = 1'b0;
`endif

endmodule
